xf_register_file: RTL and testbench

Transform-unit (XF) register and matrix storage, directly downstream of the command processor. Consumes the command processor's XF write bus (`CPAddr`/`CPData`/`CPXFWrite`) and decodes each write into position-matrix memory, normal-matrix memory, matrix-index registers or the staged viewport/projection register groups. Presents committed state and synchronous matrix read ports to the vertex transform pipeline.

---
 rtl/xf_register_file_if.sv | 9 +
 rtl/xf_register_file.sv | 142 ++++++++++++++
 tb/tb_xf_register_file.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/xf_register_file_if.sv
// rtl/xf_register_file_if.sv - command processor to XF write bus
interface xf_register_file_if;
  logic [15:0] CPAddr;
  logic [31:0] CPData;
  logic        CPXFWrite;

  modport master (output CPAddr, output CPData, output CPXFWrite);
  modport slave  (input CPAddr, input CPData, input CPXFWrite);
endinterface

// File: rtl/xf_register_file.sv
// rtl/xf_register_file.sv - XF register/matrix storage with staged viewport/projection commits
// Optional normal-matrix region built when XF_NORMAL_MATRIX_EN is defined.
module xf_register_file #(
  parameter int BAD_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  xf_register_file_if.slave    cp,
  input  logic                 MtxReadEn,
  input  logic [7:0]           MtxReadAddr,
  output logic [31:0]          MtxReadData,
  input  logic                 NrmReadEn,
  input  logic [6:0]           NrmReadAddr,
  output logic [31:0]          NrmReadData,
  output logic [31:0]          MatIdxA,
  output logic [31:0]          MatIdxB,
  output logic [191:0]         Viewport,
  output logic [223:0]         Projection,
  output logic                 ViewportUpdate,
  output logic                 ProjectionUpdate,
  output logic [BAD_CNT_W-1:0] BadWriteCount
);

  logic        wr;
  logic [15:0] vp_off;
  logic [15:0] pj_off;
  logic        hit_mtx, hit_nrm, hit_idxa, hit_idxb;
  logic        hit_vp_sh, hit_vp_cm, hit_pj_sh, hit_pj_cm, hit_bad;

  logic [31:0]          mtx_mem [256];
  logic [31:0]          mtx_rd_q;
  logic [31:0]          mat_idx_a_q, mat_idx_b_q;
  logic [4:0][31:0]     vp_sh_q;
  logic [5:0][31:0]     pj_sh_q;
  logic [5:0][31:0]     vp_q;
  logic [6:0][31:0]     pj_q;
  logic                 vp_upd_q, pj_upd_q;
  logic [BAD_CNT_W-1:0] bad_cnt_q, bad_cnt_d;

  // A strobe coincident with reset must not touch RAM or registers.
  assign wr     = cp.CPXFWrite && !reset;
  assign vp_off = cp.CPAddr - 16'h101A;
  assign pj_off = cp.CPAddr - 16'h1020;

  always_comb begin
    hit_mtx   = (cp.CPAddr[15:8] == 8'h00);
`ifdef XF_NORMAL_MATRIX_EN
    hit_nrm   = (cp.CPAddr >= 16'h0400) && (cp.CPAddr <= 16'h045F);
`else
    hit_nrm   = 1'b0;
`endif
    hit_idxa  = (cp.CPAddr == 16'h1018);
    hit_idxb  = (cp.CPAddr == 16'h1019);
    hit_vp_sh = (cp.CPAddr >= 16'h101A) && (cp.CPAddr <= 16'h101E);
    hit_vp_cm = (cp.CPAddr == 16'h101F);
    hit_pj_sh = (cp.CPAddr >= 16'h1020) && (cp.CPAddr <= 16'h1025);
    hit_pj_cm = (cp.CPAddr == 16'h1026);
    hit_bad   = !(hit_mtx || hit_nrm || hit_idxa || hit_idxb ||
                  hit_vp_sh || hit_vp_cm || hit_pj_sh || hit_pj_cm);
  end

  always_comb begin
    bad_cnt_d = bad_cnt_q;
    if (wr && hit_bad && (bad_cnt_q != {BAD_CNT_W{1'b1}}))
      bad_cnt_d = bad_cnt_q + BAD_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (wr && hit_mtx)
      mtx_mem[cp.CPAddr[7:0]] <= cp.CPData;
  end

  always_ff @(posedge clk) begin
    if (reset)
      mtx_rd_q <= '0;
    else if (MtxReadEn)
      mtx_rd_q <= mtx_mem[MtxReadAddr];
  end

`ifdef XF_NORMAL_MATRIX_EN
  logic [15:0] nrm_off;
  logic [31:0] nrm_mem [96];
  logic [31:0] nrm_rd_q;

  assign nrm_off = cp.CPAddr - 16'h0400;

  always_ff @(posedge clk) begin
    if (wr && hit_nrm)
      nrm_mem[nrm_off[6:0]] <= cp.CPData;
  end

  always_ff @(posedge clk) begin
    if (reset)
      nrm_rd_q <= '0;
    else if (NrmReadEn)
      nrm_rd_q <= (NrmReadAddr > 7'd95) ? 32'h0 : nrm_mem[NrmReadAddr];
  end

  assign NrmReadData = nrm_rd_q;
`else
  logic unused_nrm;
  assign unused_nrm  = ^{NrmReadEn, NrmReadAddr, hit_nrm};
  assign NrmReadData = 32'h0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      mat_idx_a_q <= '0;
      mat_idx_b_q <= '0;
      vp_sh_q     <= '0;
      pj_sh_q     <= '0;
      vp_q        <= '0;
      pj_q        <= '0;
      vp_upd_q    <= 1'b0;
      pj_upd_q    <= 1'b0;
      bad_cnt_q   <= '0;
    end else begin
      vp_upd_q  <= wr && hit_vp_cm;
      pj_upd_q  <= wr && hit_pj_cm;
      bad_cnt_q <= bad_cnt_d;
      if (wr && hit_idxa) mat_idx_a_q <= cp.CPData;
      if (wr && hit_idxb) mat_idx_b_q <= cp.CPData;
      for (int i = 0; i < 5; i++)
        if (wr && hit_vp_sh && (vp_off[2:0] == 3'(i))) vp_sh_q[i] <= cp.CPData;
      for (int i = 0; i < 6; i++)
        if (wr && hit_pj_sh && (pj_off[2:0] == 3'(i))) pj_sh_q[i] <= cp.CPData;
      // The commit word itself comes from the bus, the rest from the shadows.
      if (wr && hit_vp_cm) vp_q <= {cp.CPData, vp_sh_q};
      if (wr && hit_pj_cm) pj_q <= {cp.CPData, pj_sh_q};
    end
  end

  assign MtxReadData      = mtx_rd_q;
  assign MatIdxA          = mat_idx_a_q;
  assign MatIdxB          = mat_idx_b_q;
  assign Viewport         = vp_q;
  assign Projection       = pj_q;
  assign ViewportUpdate   = vp_upd_q;
  assign ProjectionUpdate = pj_upd_q;
  assign BadWriteCount    = bad_cnt_q;

endmodule

// File: tb/tb_xf_register_file.sv
// tb/tb_xf_register_file.sv - scoreboard bench for xf_register_file
// Reference model tracks registers and RAMs as plain arrays, one expected snapshot per cycle.
module tb_xf_register_file;
  localparam int BW     = 8;
  localparam int BADMAX = (1 << BW) - 1;
`ifdef XF_NORMAL_MATRIX_EN
  localparam bit NRM_EN = 1'b1;
`else
  localparam bit NRM_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         MtxReadEn, NrmReadEn;
  logic [7:0]   MtxReadAddr;
  logic [6:0]   NrmReadAddr;
  logic [31:0]  MtxReadData, NrmReadData, MatIdxA, MatIdxB;
  logic [191:0] Viewport;
  logic [223:0] Projection;
  logic         ViewportUpdate, ProjectionUpdate;
  logic [BW-1:0] BadWriteCount;

  always #5 clk = ~clk;

  xf_register_file_if cp_if ();

  xf_register_file #(.BAD_CNT_W(BW)) dut (
    .clk(clk), .reset(reset), .cp(cp_if.slave),
    .MtxReadEn(MtxReadEn), .MtxReadAddr(MtxReadAddr), .MtxReadData(MtxReadData),
    .NrmReadEn(NrmReadEn), .NrmReadAddr(NrmReadAddr), .NrmReadData(NrmReadData),
    .MatIdxA(MatIdxA), .MatIdxB(MatIdxB), .Viewport(Viewport), .Projection(Projection),
    .ViewportUpdate(ViewportUpdate), .ProjectionUpdate(ProjectionUpdate),
    .BadWriteCount(BadWriteCount)
  );

  typedef struct {
    logic [31:0]   mrd;  bit mrd_k;
    logic [31:0]   nrd;  bit nrd_k;
    logic [31:0]   ia, ib;
    logic [191:0]  vp;
    logic [223:0]  pj;
    logic          vpu, pju;
    logic [BW-1:0] bad;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int total = 0;
  int bad_n = 0;

  logic [31:0] m_mtx [256]; bit m_mtx_k [256];
  logic [31:0] m_nrm [96];  bit m_nrm_k [96];
  logic [31:0] m_vsh [5], m_psh [6], m_vp [6], m_pj [7];
  logic [31:0] m_ia, m_ib, m_mrd, m_nrd;
  bit          m_mrd_k, m_nrd_k, m_vpu, m_pju;
  int          m_bad;

  task automatic model_step(input bit r, input bit w, input logic [15:0] a, input logic [31:0] d,
                            input bit re, input logic [7:0] ra, input bit ne, input logic [6:0] na);
    exp_t e;
    int ai;
    ai = int'(a);
    if (r) begin
      m_mrd = 0; m_mrd_k = 1; m_nrd = 0; m_nrd_k = 1;
      m_ia = 0; m_ib = 0; m_vpu = 0; m_pju = 0; m_bad = 0;
      foreach (m_vsh[i]) m_vsh[i] = 0;
      foreach (m_psh[i]) m_psh[i] = 0;
      foreach (m_vp[i])  m_vp[i]  = 0;
      foreach (m_pj[i])  m_pj[i]  = 0;
    end else begin
      m_vpu = 0; m_pju = 0;
      if (re) begin m_mrd = m_mtx[ra]; m_mrd_k = m_mtx_k[ra]; end
      if (!NRM_EN) begin m_nrd = 0; m_nrd_k = 1; end
      else if (ne) begin
        if (na > 95) begin m_nrd = 0; m_nrd_k = 1; end
        else begin m_nrd = m_nrm[na]; m_nrd_k = m_nrm_k[na]; end
      end
      if (w) begin
        if (ai < 256) begin m_mtx[ai] = d; m_mtx_k[ai] = 1; end
        else if (NRM_EN && ai >= 'h400 && ai < 'h460) begin m_nrm[ai-'h400] = d; m_nrm_k[ai-'h400] = 1; end
        else if (ai == 'h1018) m_ia = d;
        else if (ai == 'h1019) m_ib = d;
        else if (ai >= 'h101A && ai <= 'h101E) m_vsh[ai-'h101A] = d;
        else if (ai == 'h101F) begin
          for (int i = 0; i < 5; i++) m_vp[i] = m_vsh[i];
          m_vp[5] = d; m_vpu = 1;
        end
        else if (ai >= 'h1020 && ai <= 'h1025) m_psh[ai-'h1020] = d;
        else if (ai == 'h1026) begin
          for (int i = 0; i < 6; i++) m_pj[i] = m_psh[i];
          m_pj[6] = d; m_pju = 1;
        end
        else if (m_bad < BADMAX) m_bad++;
      end
    end
    e.mrd = m_mrd; e.mrd_k = m_mrd_k; e.nrd = m_nrd; e.nrd_k = m_nrd_k;
    e.ia = m_ia; e.ib = m_ib; e.vpu = m_vpu; e.pju = m_pju; e.bad = BW'(m_bad);
    for (int i = 0; i < 6; i++) e.vp[i*32 +: 32] = m_vp[i];
    for (int i = 0; i < 7; i++) e.pj[i*32 +: 32] = m_pj[i];
    sb.push_back(e);
  endtask

  task automatic cyc(input bit r, input bit w, input logic [15:0] a, input logic [31:0] d,
                     input bit re, input logic [7:0] ra, input bit ne, input logic [6:0] na);
    @(negedge clk);
    reset = r; cp_if.CPXFWrite = w; cp_if.CPAddr = a; cp_if.CPData = d;
    MtxReadEn = re; MtxReadAddr = ra; NrmReadEn = ne; NrmReadAddr = na;
    model_step(r, w, a, d, re, ra, ne, na);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    cyc(0, 1, a, d, 0, 8'h0, 0, 7'h0);
  endtask

  task automatic idle();
    cyc(0, 0, 16'h0, 32'h0, 0, 8'h0, 0, 7'h0);
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      me = sb.pop_front();
      if (me.mrd_k) chk("mtx_rd", 256'(MtxReadData), 256'(me.mrd));
      if (me.nrd_k) chk("nrm_rd", 256'(NrmReadData), 256'(me.nrd));
      chk("mat_idx_a", 256'(MatIdxA), 256'(me.ia));
      chk("mat_idx_b", 256'(MatIdxB), 256'(me.ib));
      chk("viewport", 256'(Viewport), 256'(me.vp));
      chk("projection", 256'(Projection), 256'(me.pj));
      chk("vp_update", 256'(ViewportUpdate), 256'(me.vpu));
      chk("pj_update", 256'(ProjectionUpdate), 256'(me.pju));
      chk("bad_count", 256'(BadWriteCount), 256'(me.bad));
    end
  end

  initial begin
    logic [15:0] a;
    int sel;
    foreach (m_mtx_k[i]) m_mtx_k[i] = 0;
    foreach (m_nrm_k[i]) m_nrm_k[i] = 0;
    m_mrd_k = 0; m_nrd_k = 0;
    reset = 1; cp_if.CPXFWrite = 0; cp_if.CPAddr = 0; cp_if.CPData = 0;
    MtxReadEn = 0; MtxReadAddr = 0; NrmReadEn = 0; NrmReadAddr = 0;

    cyc(1, 0, 16'h0, 32'h0, 0, 8'h0, 0, 7'h0);
    cyc(1, 1, 16'h1018, 32'hFFFF, 1, 8'h0, 1, 7'h0);
    idle();

    wr(16'h0005, 32'hDEADBEEF);
    cyc(0, 0, 16'h0, 32'h0, 1, 8'd5, 0, 7'h0);
    cyc(0, 1, 16'h0005, 32'h00001234, 1, 8'd5, 0, 7'h0);
    cyc(0, 0, 16'h0, 32'h0, 1, 8'd5, 0, 7'h0);
    idle();

    for (int i = 0; i < 6; i++) wr(16'h101A + 16'(i), 32'h11 * (i + 1));
    idle(); idle();
    wr(16'h1026, 32'h7);
    wr(16'h101C, 32'hAA);
    wr(16'h101F, 32'h99);
    wr(16'h101F, 32'h98);
    wr(16'h1026, 32'h8);
    idle();

    for (int i = 0; i < 300; i++) wr(16'h2000, 32'(i));
    wr(16'h0400, 32'h1);
    wr(16'h045F, 32'h2);
    wr(16'h0460, 32'h3);
    wr(16'h0100, 32'h4);
    cyc(0, 0, 16'h0, 32'h0, 0, 8'h0, 1, 7'd0);
    cyc(0, 0, 16'h0, 32'h0, 0, 8'h0, 1, 7'd95);
    cyc(0, 0, 16'h0, 32'h0, 0, 8'h0, 1, 7'd100);
    idle();

    wr(16'h101A, 32'h5);
    cyc(1, 1, 16'h101F, 32'hBAD, 0, 8'h0, 0, 7'h0);
    wr(16'h101F, 32'h9);
    wr(16'h1018, 32'h12345678);
    idle();

    for (int n = 0; n < 2500; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: a = 16'($urandom_range(0, 15));
        3:       a = 16'h0400 + 16'($urandom_range(0, 99));
        8:       a = 16'($urandom);
        9:       a = ($urandom_range(0, 1) != 0) ? 16'h00FF : 16'h0100;
        default: a = 16'h1018 + 16'($urandom_range(0, 14));
      endcase
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), a, $urandom,
          ($urandom_range(0, 1) != 0), 8'($urandom_range(0, 15)),
          ($urandom_range(0, 1) != 0), 7'($urandom_range(0, 100)));
    end
    idle(); idle();

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #2;
    total++;
    if (sb.size() != 0) begin
      bad_n++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad_n);
    $finish;
  end
endmodule
